// File: rtl/tag_stream_generator_pkg.sv
// Shared types and helpers for the synthetic tag-stream generator.
package tag_stream_pkg;

  localparam int TAG_TIME_W  = 64;
  localparam int CHANNEL_W   = 6;
  localparam int MAX_CHANNEL = 18;
  localparam int CH_NUM_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } gen_state_t;

  typedef logic [TAG_TIME_W-1:0]       tag_time_t;
  typedef logic signed [CHANNEL_W-1:0] channel_t;
  typedef logic [CH_NUM_W-1:0]         ch_num_t;

  function automatic ch_num_t next_channel(input ch_num_t ch, input ch_num_t first,
                                           input ch_num_t last);
    return (ch >= last) ? first : ch + ch_num_t'(1);
  endfunction

  function automatic logic channel_range_ok(input ch_num_t first, input ch_num_t last);
    return (first >= ch_num_t'(1)) && (first <= ch_num_t'(MAX_CHANNEL)) &&
           (last >= first) && (last <= ch_num_t'(MAX_CHANNEL));
  endfunction

  // Falling edges are reported as the negated channel number.
  function automatic channel_t signed_channel(input ch_num_t ch, input logic falling);
    channel_t c;
    c = channel_t'({1'b0, ch});
    return falling ? -c : c;
  endfunction

endpackage

// File: rtl/tag_stream_generator_if.sv
// Tag-stream beat bus: WORD_WIDTH lanes of {tagtime, channel} qualified by tkeep.
interface tag_stream_generator_if #(
  parameter int WORD_WIDTH = 4
);
  import tag_stream_pkg::*;

  // A beat moves on a clock edge where tvalid && tready; once tvalid is high the
  // master keeps tvalid and all data stable until that edge, and tready may toggle freely.
  logic                  tvalid;
  logic                  tready;
  tag_time_t             tagtime [WORD_WIDTH];
  channel_t              channel [WORD_WIDTH];
  logic [WORD_WIDTH-1:0] tkeep;

  modport master (output tvalid, tagtime, channel, tkeep, input tready);
  modport slave  (input tvalid, tagtime, channel, tkeep, output tready);

endinterface

// File: rtl/tag_stream_generator_channel_seq.sv
// Registered channel rotator: holds the WORD_WIDTH channels of the next beat.
module tag_gen_channel_seq
  import tag_stream_pkg::*;
#(
  parameter int WORD_WIDTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    init,
  input  logic    advance,
  input  ch_num_t ch_first,
  input  ch_num_t ch_last,
  output ch_num_t lane_ch [WORD_WIDTH]
);

  ch_num_t nxt [WORD_WIDTH];

  // The rotation continues from the last lane of the previous beat.
  always_comb begin
    ch_num_t c;
    c = init ? ch_first : next_channel(lane_ch[WORD_WIDTH-1], ch_first, ch_last);
    for (int i = 0; i < WORD_WIDTH; i++) begin
      nxt[i] = c;
      c      = next_channel(c, ch_first, ch_last);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORD_WIDTH; i++) lane_ch[i] <= '0;
    end else if (init || advance) begin
      for (int i = 0; i < WORD_WIDTH; i++) lane_ch[i] <= nxt[i];
    end
  end

endmodule

// File: rtl/tag_stream_generator.sv
// Synthetic tag source for the measurement tag-stream input.
// Define TAG_GEN_SPARSE_EN to thin lanes pseudo-randomly with a 16-bit LFSR.
module tag_stream_generator
  import tag_stream_pkg::*;
#(
  parameter int WORD_WIDTH = 4,
  parameter int PERIOD_W   = 32,
  parameter int COUNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  tag_time_t              cfg_start_time,
  input  logic [PERIOD_W-1:0]    cfg_period,
  input  logic [COUNT_W-1:0]     cfg_count,
  input  ch_num_t                cfg_ch_first,
  input  ch_num_t                cfg_ch_last,
  input  logic                   cfg_falling,
  tag_stream_generator_if.master m_axis,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_error,
  output gen_state_t             dbg_state
);

  gen_state_t          state;
  logic                load_phase;
  tag_time_t           base;
  logic [PERIOD_W-1:0] period_q;
  logic [COUNT_W-1:0]  count_q;
  logic [COUNT_W-1:0]  emitted;
  ch_num_t             ch_first_q;
  ch_num_t             ch_last_q;
  logic                falling_q;
  logic                stop_pending;
  logic                last_beat;

  ch_num_t               seq_ch [WORD_WIDTH];
  tag_time_t             lane_time [WORD_WIDTH];
  tag_time_t             next_base;
  logic [COUNT_W-1:0]    remaining;
  logic [COUNT_W-1:0]    kept_n;
  logic [COUNT_W-1:0]    emitted_next;
  logic [COUNT_W:0]      emitted_sum;
  logic [WORD_WIDTH-1:0] in_count;
  logic [WORD_WIDTH-1:0] keep;
  logic                  beat_last;
  logic                  xfer;
  logic                  end_run;
  logic                  present;
  logic                  seq_init;

  assign xfer      = m_axis.tvalid && m_axis.tready;
  assign end_run   = (state == RUN) && xfer && (last_beat || stop_pending || cfg_stop);
  // A new beat is registered at the end of LOAD and on every transfer that keeps the run going.
  assign present   = ((state == LOAD) && load_phase && !cfg_stop) ||
                     ((state == RUN) && xfer && !end_run);
  assign seq_init  = (state == LOAD) && !load_phase;
  assign dbg_state = state;

  tag_gen_channel_seq #(.WORD_WIDTH(WORD_WIDTH)) u_channel_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (seq_init),
    .advance  (present),
    .ch_first (ch_first_q),
    .ch_last  (ch_last_q),
    .lane_ch  (seq_ch)
  );

`ifdef TAG_GEN_SPARSE_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [15:0] lfsr_src;

  // Galois form of x^16+x^14+x^13+x^11+1; a beat presented on a transfer sees the advanced state.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign lfsr_src  = xfer ? lfsr_next : lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else if (xfer) lfsr <= lfsr_next;
  end
`endif

  always_comb begin
    tag_time_t t;
    t = base;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      lane_time[i] = t;
      t = t + tag_time_t'(period_q);
    end
    next_base = t;
  end

  assign remaining = count_q - emitted;

  always_comb begin
    in_count = '0;
    kept_n   = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      in_count[i] = (count_q == '0) || (COUNT_W'(i) < remaining);
    end
`ifdef TAG_GEN_SPARSE_EN
    keep = in_count & ~lfsr_src[WORD_WIDTH-1:0];
`else
    keep = in_count;
`endif
    for (int i = 0; i < WORD_WIDTH; i++) kept_n = kept_n + COUNT_W'(keep[i]);
  end

  // Dropped lanes do not count, so the run ends once the kept tags reach the target.
  assign beat_last    = (count_q != '0) && (kept_n >= remaining);
  assign emitted_sum  = {1'b0, emitted} + {1'b0, kept_n};
  assign emitted_next = emitted_sum[COUNT_W] ? '1 : emitted_sum[COUNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      load_phase    <= 1'b0;
      base          <= '0;
      period_q      <= '0;
      count_q       <= '0;
      emitted       <= '0;
      ch_first_q    <= '0;
      ch_last_q     <= '0;
      falling_q     <= 1'b0;
      stop_pending  <= 1'b0;
      last_beat     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_error     <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tkeep  <= '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
        m_axis.tagtime[i] <= '0;
        m_axis.channel[i] <= '0;
      end
    end else begin
      done      <= 1'b0;
      cfg_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (channel_range_ok(cfg_ch_first, cfg_ch_last)) begin
              base         <= cfg_start_time;
              period_q     <= cfg_period;
              count_q      <= cfg_count;
              ch_first_q   <= cfg_ch_first;
              ch_last_q    <= cfg_ch_last;
              falling_q    <= cfg_falling;
              emitted      <= '0;
              stop_pending <= 1'b0;
              load_phase   <= 1'b0;
              busy         <= 1'b1;
              state        <= LOAD;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (cfg_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!load_phase) begin
            load_phase <= 1'b1;
          end else begin
            load_phase <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (end_run) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b1;
            m_axis.tvalid <= 1'b0;
            m_axis.tkeep  <= '0;
          end else if (cfg_stop) begin
            stop_pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (present) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tkeep  <= keep;
        for (int i = 0; i < WORD_WIDTH; i++) begin
          m_axis.tagtime[i] <= in_count[i] ? lane_time[i] : '0;
          m_axis.channel[i] <= in_count[i] ? signed_channel(seq_ch[i], falling_q) : '0;
        end
        base      <= next_base;
        emitted   <= emitted_next;
        last_beat <= beat_last;
      end
    end
  end

endmodule

// File: tb/tb_tag_stream_generator.sv
// Self-checking bench for tag_stream_generator: run table plus hand-written corner sequences.
module tb_tag_stream_generator;
  import tag_stream_pkg::*;

  localparam int WW     = 4;
  localparam int LANE_W = 1 + TAG_TIME_W + CHANNEL_W;

  typedef struct {
    string       name;
    logic [63:0] start_time;
    logic [31:0] period;
    logic [31:0] count;
    logic [4:0]  ch_first;
    logic [4:0]  ch_last;
    logic        falling;
    int          ready_pct;
    int          stall0;
    int          stop_after;
    int          exp_beats;
    int          exp_tags;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic        cfg_stop;
  logic [63:0] cfg_start_time;
  logic [31:0] cfg_period;
  logic [31:0] cfg_count;
  logic [4:0]  cfg_ch_first;
  logic [4:0]  cfg_ch_last;
  logic        cfg_falling;
  logic        busy;
  logic        done;
  logic        cfg_error;
  gen_state_t  dbg_state;

  tag_stream_generator_if #(.WORD_WIDTH(WW)) m_axis ();

  tag_stream_generator #(.WORD_WIDTH(WW), .PERIOD_W(32), .COUNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_start_time (cfg_start_time),
    .cfg_period     (cfg_period),
    .cfg_count      (cfg_count),
    .cfg_ch_first   (cfg_ch_first),
    .cfg_ch_last    (cfg_ch_last),
    .cfg_falling    (cfg_falling),
    .m_axis         (m_axis),
    .busy           (busy),
    .done           (done),
    .cfg_error      (cfg_error),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  logic [LANE_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int beats_seen = 0;
  int tags_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: tag k of a run is start + k*period on channel first + k mod span.
  function automatic logic [LANE_W-1:0] model_lane(input vec_t v, input int k);
    int          n;
    logic [4:0]  c;
    logic [63:0] t;
    logic [5:0]  ch;
    if (v.count != 32'd0 && 32'(k) >= v.count) return '0;
    n  = int'(v.ch_last) - int'(v.ch_first) + 1;
    c  = v.ch_first + 5'(k % n);
    t  = v.start_time + 64'(k) * 64'(v.period);
    ch = v.falling ? 6'd0 - {1'b0, c} : {1'b0, c};
    return {1'b1, t, ch};
  endfunction

  function automatic logic [LANE_W-1:0] lane_word(input int i);
    return {m_axis.tkeep[i], m_axis.tagtime[i], m_axis.channel[i]};
  endfunction

  // Monitor: decides at the falling edge what the next rising edge will transfer.
  logic [LANE_W-1:0] held [WW];
  bit prev_stall = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", m_axis.tvalid, 1);
        for (int i = 0; i < WW; i++) check("hold_lane", lane_word(i), held[i]);
      end
      if (done) begin
        done_cnt++;
        check("done_with_busy_tvalid", {busy, m_axis.tvalid}, 0);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        beats_seen++;
        tags_seen += $countones(m_axis.tkeep);
        for (int i = 0; i < WW; i++) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected_lane: got %0h want none", lane_word(i));
          end else begin
            check("lane", lane_word(i), exp_q.pop_front());
          end
        end
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      if (prev_stall) for (int i = 0; i < WW; i++) held[i] = lane_word(i);
    end
  end

  task automatic apply_cfg(input vec_t v);
    cfg_start_time = v.start_time;
    cfg_period     = v.period;
    cfg_count      = v.count;
    cfg_ch_first   = v.ch_first;
    cfg_ch_last    = v.ch_last;
    cfg_falling    = v.falling;
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(posedge clk) #1;
      cyc++;
    end
  endtask

  task automatic finish_run(input string name, input int beats, input int tags);
    repeat (3) @(posedge clk);
    #1;
    check({name, ".done_count"}, done_cnt, 1);
    check({name, ".beats"}, beats_seen, beats);
    check({name, ".tags"}, tags_seen, tags);
    check({name, ".sb_empty"}, exp_q.size(), 0);
    check({name, ".busy_idle"}, busy, 0);
    check({name, ".state_idle"}, dbg_state, IDLE);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int  cyc = 0;
    bit  stop_sent = 0;
    done_cnt = 0; beats_seen = 0; tags_seen = 0;
    for (int b = 0; b < v.exp_beats; b++)
      for (int i = 0; i < WW; i++) exp_q.push_back(model_lane(v, b * WW + i));
    @(posedge clk) #1;
    apply_cfg(v);
    m_axis.tready = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk) #1;
    cfg_start = 1'b0;
    check({v.name, ".busy_after_start"}, busy, 1);
    check({v.name, ".tvalid_e1"}, m_axis.tvalid, 0);
    @(posedge clk) #1;
    check({v.name, ".tvalid_e2"}, m_axis.tvalid, 0);
    @(posedge clk) #1;
    check({v.name, ".tvalid_first"}, m_axis.tvalid, 1);
    while (done_cnt == 0 && cyc < 3000) begin
      if (cyc < v.stall0) m_axis.tready = 1'b0;
      else m_axis.tready = ($urandom_range(1, 100) <= v.ready_pct);
      if (v.stop_after > 0 && !stop_sent && beats_seen == v.stop_after - 1) begin
        cfg_stop  = 1'b1;
        stop_sent = 1;
      end else begin
        cfg_stop = 1'b0;
      end
      @(posedge clk) #1;
      cyc++;
    end
    cfg_stop = 1'b0;
    m_axis.tready = 1'b0;
    finish_run(v.name, v.exp_beats, v.exp_tags);
  endtask

  task automatic reject_seq();
    logic [4:0] bad_first [3];
    logic [4:0] bad_last  [3];
    bad_first = '{5'd0, 5'd5, 5'd1};
    bad_last  = '{5'd3, 5'd4, 5'd19};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk) #1;
      cfg_ch_first = bad_first[k];
      cfg_ch_last  = bad_last[k];
      cfg_start    = 1'b1;
      @(posedge clk) #1;
      cfg_start = 1'b0;
      check("reject.cfg_error", cfg_error, 1);
      check("reject.busy", busy, 0);
      @(posedge clk) #1;
      check("reject.error_one_cycle", cfg_error, 0);
      check("reject.state", dbg_state, IDLE);
    end
  endtask

  task automatic ignore_seq(input vec_t a);
    done_cnt = 0; beats_seen = 0; tags_seen = 0;
    for (int i = 0; i < WW; i++) exp_q.push_back(model_lane(a, i));
    @(posedge clk) #1;
    apply_cfg(a);
    m_axis.tready = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk) #1;
    cfg_start = 1'b0;
    repeat (3) @(posedge clk) #1;
    check("ignore.busy_run", busy, 1);
    cfg_start_time = 64'd99999;
    cfg_ch_first   = 5'd7;
    cfg_ch_last    = 5'd7;
    cfg_start      = 1'b1;
    @(posedge clk) #1;
    cfg_start = 1'b0;
    check("ignore.no_error", cfg_error, 0);
    check("ignore.still_busy", busy, 1);
    cfg_stop = 1'b1;
    @(posedge clk) #1;
    cfg_stop = 1'b0;
    check("ignore.stop_waits_handshake", {m_axis.tvalid, busy}, 2'b11);
    repeat (2) @(posedge clk) #1;
    m_axis.tready = 1'b1;
    wait_done(50);
    m_axis.tready = 1'b0;
    finish_run("ignore", 1, 4);
  endtask

  task automatic reset_seq(input vec_t a);
    done_cnt = 0;
    @(posedge clk) #1;
    apply_cfg(a);
    m_axis.tready = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk) #1;
    cfg_start = 1'b0;
    repeat (2) @(posedge clk) #1;
    check("reset.pre_tvalid", m_axis.tvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("reset.tvalid_async", m_axis.tvalid, 0);
    check("reset.busy_async", busy, 0);
    check("reset.tkeep_async", m_axis.tkeep, 0);
    check("reset.tagtime_async", m_axis.tagtime[1], 0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk) #1;
    check("reset.no_done", done_cnt, 0);
    check("reset.state", dbg_state, IDLE);
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs [7];
    vec_t aux;
    vecs[0] = '{"basic",        64'd1000, 32'd300, 32'd8,  5'd1,  5'd3,  1'b0, 100, 0, 0, 2,  8};
    vecs[1] = '{"partial",      64'd1000, 32'd300, 32'd6,  5'd1,  5'd3,  1'b0, 100, 0, 0, 2,  6};
    vecs[2] = '{"backpressure", 64'd1000, 32'd300, 32'd13, 5'd1,  5'd3,  1'b0, 60,  5, 0, 4,  13};
    vecs[3] = '{"stop_falling", 64'd5000, 32'd1000, 32'd0, 5'd5,  5'd5,  1'b1, 100, 0, 3, 3,  12};
    vecs[4] = '{"wrap",         64'hFFFF_FFFF_FFFF_FDA8, 32'd300, 32'd4, 5'd7, 5'd9, 1'b0, 100, 0, 0, 1, 4};
    vecs[5] = '{"single",       64'd123,  32'd0,   32'd1,  5'd17, 5'd18, 1'b1, 100, 0, 0, 1,  1};
    vecs[6] = '{"rotation",     64'd42,   32'd777, 32'd37, 5'd2,  5'd18, 1'b1, 50,  2, 0, 10, 37};

    rst_n          = 1'b0;
    cfg_start      = 1'b0;
    cfg_stop       = 1'b0;
    cfg_start_time = '0;
    cfg_period     = '0;
    cfg_count      = '0;
    cfg_ch_first   = 5'd1;
    cfg_ch_last    = 5'd1;
    cfg_falling    = 1'b0;
    m_axis.tready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.tvalid", m_axis.tvalid, 0);
    check("reset.tkeep", m_axis.tkeep, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.cfg_error", cfg_error, 0);
    check("reset.tagtime0", m_axis.tagtime[0], 0);
    check("reset.channel3", m_axis.channel[3], 0);
    check("reset.state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(posedge clk) #1;

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    reject_seq();
    aux = '{"ignore", 64'd500, 32'd10, 32'd0, 5'd1, 5'd2, 1'b0, 100, 0, 0, 1, 4};
    ignore_seq(aux);
    reset_seq(vecs[0]);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
